// File: rtl/alu_issue_sched_pkg.sv
// Shared types for the dual-ALU issue scheduler: ALU payload, issue-slot record, slot count.
package alu_issue_sched_pkg;

  localparam int NUM_ALU_SLOTS = 2;
  localparam int MAX_TAG_W     = 5;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic [4:0]  dst;
  } aluStruct;

  // Tag is sized for the largest supported reservation station (32 entries).
  typedef struct packed {
    logic                 valid;
    aluStruct             op;
    logic [MAX_TAG_W-1:0] tag;
  } issueSlotStruct;

endpackage

// File: rtl/alu_issue_sched_if.sv
// Request/issue bundle between the reservation station, the scheduler and the FU cluster.
interface alu_issue_sched_if #(
  parameter int NUM_ENTRIES = 8
);
  import alu_issue_sched_pkg::*;

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]                      req_valid;
  aluStruct [NUM_ENTRIES-1:0]                  req_op;
  logic [NUM_ALU_SLOTS-1:0]                    fu_stall;
  logic                                        flush;
  logic [NUM_ALU_SLOTS-1:0][NUM_ENTRIES-1:0]   grant;
  logic [NUM_ALU_SLOTS-1:0]                    issue_valid;
  aluStruct [NUM_ALU_SLOTS-1:0]                issue_op;
  logic [NUM_ALU_SLOTS-1:0][IDX_W-1:0]         issue_tag;

  modport master (
    output req_valid, req_op, fu_stall, flush,
    input  grant, issue_valid, issue_op, issue_tag
  );

  modport slave (
    input  req_valid, req_op, fu_stall, flush,
    output grant, issue_valid, issue_op, issue_tag
  );

endinterface

// File: rtl/alu_issue_picker.sv
// Masked rotate-and-find-first: first set bit of (req & ~mask) scanning upward from ptr, wrapping.
module alu_issue_picker #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic [NUM_ENTRIES-1:0]         req_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] ptr_i,
  input  logic [NUM_ENTRIES-1:0]         mask_i,
  output logic [NUM_ENTRIES-1:0]         gnt_o,
  output logic [$clog2(NUM_ENTRIES)-1:0] idx_o,
  output logic                           vld_o
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] eff;
  logic [IDX_W-1:0]       cand;

  // Power-of-two entry count lets the index adder wrap for free.
  always_comb begin
    eff   = req_i & ~mask_i;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      cand = ptr_i + IDX_W'(k);
      if (!vld_o && eff[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Dual-slot ALU issue scheduler. Define ALU_SCHED_RR_EN for round-robin priority;
// otherwise fixed lowest-index-first priority with no pointer register.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_issue_sched_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]   req_eff;
  logic [NUM_ALU_SLOTS-1:0] open;
  logic [IDX_W-1:0]         ptr;

  logic [NUM_ENTRIES-1:0]   gnt0, gnt1;
  logic [IDX_W-1:0]         idx0, idx1;
  logic                     vld0, vld1;

  logic [NUM_ALU_SLOTS-1:0]            slot_vld;
  logic [NUM_ALU_SLOTS-1:0][IDX_W-1:0] slot_idx;

  logic [NUM_ALU_SLOTS-1:0]            valid_q, valid_d;
  aluStruct [NUM_ALU_SLOTS-1:0]        op_q, op_d;
  logic [NUM_ALU_SLOTS-1:0][IDX_W-1:0] tag_q, tag_d;

  // Grants are forced off while reset is asserted.
  assign req_eff = rst_n ? bus.req_valid : '0;
  assign open    = ~bus.fu_stall & {NUM_ALU_SLOTS{~bus.flush}};

  alu_issue_picker #(.NUM_ENTRIES(NUM_ENTRIES)) u_pick0 (
    .req_i  (req_eff),
    .ptr_i  (ptr),
    .mask_i ('0),
    .gnt_o  (gnt0),
    .idx_o  (idx0),
    .vld_o  (vld0)
  );

  alu_issue_picker #(.NUM_ENTRIES(NUM_ENTRIES)) u_pick1 (
    .req_i  (req_eff),
    .ptr_i  (ptr),
    .mask_i (gnt0),
    .gnt_o  (gnt1),
    .idx_o  (idx1),
    .vld_o  (vld1)
  );

  // First pick feeds the lowest open slot; second pick only reaches slot 1 when slot 0 took the first.
  always_comb begin
    slot_vld    = '0;
    slot_idx[0] = idx0;
    slot_idx[1] = idx0;
    if (open[0]) begin
      slot_vld[0] = vld0;
      if (open[1]) begin
        slot_vld[1] = vld1;
        slot_idx[1] = idx1;
      end
    end else if (open[1]) begin
      slot_vld[1] = vld0;
    end
  end

  assign bus.grant[0] = slot_vld[0] ? gnt0 : '0;
  assign bus.grant[1] = slot_vld[1] ? (open[0] ? gnt1 : gnt0) : '0;

`ifdef ALU_SCHED_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Pointer advances past the last-granted entry in priority order.
  always_comb begin
    ptr_d = ptr_q;
    if (|slot_vld) ptr_d = (slot_vld[1] ? slot_idx[1] : slot_idx[0]) + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Flush clears both slots even if stalled; a stalled slot otherwise holds everything.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    tag_d   = tag_q;
    for (int s = 0; s < NUM_ALU_SLOTS; s++) begin
      if (bus.flush) begin
        valid_d[s] = 1'b0;
      end else if (!bus.fu_stall[s]) begin
        valid_d[s] = slot_vld[s];
        if (slot_vld[s]) begin
          op_d[s]  = bus.req_op[slot_idx[s]];
          tag_d[s] = slot_idx[s];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      op_q    <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.issue_valid = valid_q;
  assign bus.issue_op    = op_q;
  assign bus.issue_tag   = tag_q;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed plus randomized bench for alu_issue_sched against a priority-list reference model.
module tb_alu_issue_sched;
  import alu_issue_sched_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_sched_if #(.NUM_ENTRIES(N)) bus();

  alu_issue_sched #(.NUM_ENTRIES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  issueSlotStruct m_slot [2];
  int             m_ptr;
  int             e_idx  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [1:0] stall, input logic fl);
    logic [63:0] r;
    bus.req_valid = req;
    bus.fu_stall  = stall;
    bus.flush     = fl;
    for (int i = 0; i < N; i++) begin
      r = {$urandom, $urandom};
      bus.req_op[i] = r[$bits(aluStruct)-1:0];
    end
  endtask

  // Build the ready list in priority order, then hand it to the open slots.
  task automatic model_pick();
    int  pick[$];
    bit  o0, o1;
    int  e;
    e_idx[0] = -1;
    e_idx[1] = -1;
    for (int k = 0; k < N; k++) begin
`ifdef ALU_SCHED_RR_EN
      e = (m_ptr + k) % N;
`else
      e = k;
`endif
      if (bus.req_valid[e] && pick.size() < 2) pick.push_back(e);
    end
    o0 = !bus.fu_stall[0] && !bus.flush;
    o1 = !bus.fu_stall[1] && !bus.flush;
    if (o0 && o1) begin
      if (pick.size() > 0) e_idx[0] = pick[0];
      if (pick.size() > 1) e_idx[1] = pick[1];
    end else if (o0) begin
      if (pick.size() > 0) e_idx[0] = pick[0];
    end else if (o1) begin
      if (pick.size() > 0) e_idx[1] = pick[0];
    end
  endtask

  task automatic cycle(input string tag);
    logic [N-1:0]   exp_g;
    issueSlotStruct nxt [2];
    #2;
    model_pick();
    for (int s = 0; s < 2; s++) begin
      exp_g = '0;
      if (e_idx[s] >= 0) exp_g[e_idx[s]] = 1'b1;
      chk($sformatf("%s_grant%0d", tag, s), 64'(bus.grant[s]), 64'(exp_g));
      chk($sformatf("%s_ivld%0d", tag, s), 64'(bus.issue_valid[s]), 64'(m_slot[s].valid));
      chk($sformatf("%s_itag%0d", tag, s), 64'(bus.issue_tag[s]), 64'(m_slot[s].tag));
      chk($sformatf("%s_iop%0d", tag, s), 64'(bus.issue_op[s]), 64'(m_slot[s].op));
    end
    for (int s = 0; s < 2; s++) begin
      nxt[s] = m_slot[s];
      if (bus.flush) begin
        nxt[s].valid = 1'b0;
      end else if (!bus.fu_stall[s]) begin
        nxt[s].valid = (e_idx[s] >= 0);
        if (e_idx[s] >= 0) begin
          nxt[s].op  = bus.req_op[e_idx[s]];
          nxt[s].tag = MAX_TAG_W'(e_idx[s]);
        end
      end
    end
`ifdef ALU_SCHED_RR_EN
    if (e_idx[1] >= 0)      m_ptr = (e_idx[1] + 1) % N;
    else if (e_idx[0] >= 0) m_ptr = (e_idx[0] + 1) % N;
`endif
    @(posedge clk);
    #1;
    m_slot[0] = nxt[0];
    m_slot[1] = nxt[1];
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'hFF, 2'b00, 1'b0);
    m_slot[0] = '0;
    m_slot[1] = '0;
    m_ptr     = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant0", 64'(bus.grant[0]), 64'd0);
    chk("rst_grant1", 64'(bus.grant[1]), 64'd0);
    chk("rst_ivld",   64'(bus.issue_valid), 64'd0);
    chk("rst_itag",   64'(bus.issue_tag), 64'd0);
    chk("rst_iop",    64'(bus.issue_op[0]) | 64'(bus.issue_op[1]), 64'd0);

    rst_n = 1'b1;
    drive(8'hFF, 2'b00, 1'b0);
    #1;
    chk("rel_grant0_e0", 64'(bus.grant[0]), 64'h01);
    chk("rel_grant1_e1", 64'(bus.grant[1]), 64'h02);
    cycle("rst_rel");

    drive(8'h20, 2'b00, 1'b0);
    cycle("single");
    drive(8'h00, 2'b00, 1'b0);
    cycle("idle");

    drive(8'hFF, 2'b00, 1'b0);
    cycle("preload");
    for (int i = 0; i < 3; i++) begin
      drive(8'h06, 2'b01, 1'b0);
      cycle("stall0");
    end
    drive(8'h00, 2'b00, 1'b0);
    cycle("unstall");

    for (int i = 0; i < 5; i++) begin
      drive(8'hFF, 2'b00, 1'b0);
      cycle("rr");
    end

    drive(8'h40, 2'b00, 1'b0);
    cycle("ptr_to7");
    drive(8'h81, 2'b00, 1'b0);
    cycle("wrap");
    drive(8'hFF, 2'b00, 1'b0);
    cycle("after_wrap");

    drive(8'hFF, 2'b00, 1'b0);
    cycle("fl_load");
    drive(8'hFF, 2'b11, 1'b0);
    cycle("fl_stall");
    drive(8'hFF, 2'b11, 1'b1);
    cycle("flush");
    drive(8'h00, 2'b00, 1'b0);
    cycle("post_flush");

    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom),
            ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
            ($urandom_range(0, 15) == 0));
      cycle("rand");
    end

    drive(8'hFF, 2'b00, 1'b0);
    cycle("pre_mid_rst");
    rst_n = 1'b0;
    #2;
    chk("midrst_grant0", 64'(bus.grant[0]), 64'd0);
    chk("midrst_grant1", 64'(bus.grant[1]), 64'd0);
    chk("midrst_ivld",   64'(bus.issue_valid), 64'd0);
    chk("midrst_itag",   64'(bus.issue_tag), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
